// File: rtl/tnn_neuron_frame.sv
// Serial feature framer for one ternary-NN neuron: collects up to six 3-bit
// features, settles the neuron inputs, samples the decision and hands it on.
module tnn_neuron_frame #(
  parameter int unsigned N_FEAT = 6,
  parameter int unsigned FEAT_W = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FEAT_W-1:0] in_feat,
  input  logic              in_last,
  output logic [FEAT_W-1:0] input_a,
  output logic [FEAT_W-1:0] input_b,
  output logic [FEAT_W-1:0] input_c,
  output logic [FEAT_W-1:0] input_d,
  output logic [FEAT_W-1:0] input_e,
  output logic [FEAT_W-1:0] input_f,
  input  logic              cgp_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_class,
  output logic              out_err,
  output logic [7:0]        out_seq
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SEQ_W = 8;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_FEAT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               ready_en_q;
  logic               in_ready_q, in_ready_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FEAT_W-1:0]  slot_q [N_FEAT];
  logic [FEAT_W-1:0]  slot_d [N_FEAT];
  logic               out_valid_q, out_valid_d;
  logic               out_class_q, out_class_d;
  logic               out_err_q, out_err_d;
  logic [SEQ_W-1:0]   out_seq_q, out_seq_d;
  logic               accept_c;
  logic               deliver_c;

  assign accept_c  = in_valid & in_ready_q;
  assign deliver_c = out_valid_q & out_ready;

  // Next-state and datapath update for the fill / settle / hold cycle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_err_d   = out_err_q;
    out_seq_d   = out_seq_q;

    case (state_q)
      S_FILL: begin
        if (accept_c) begin
          // First beat of a frame wipes the previous frame's tail slots.
          if (idx_q == '0) begin
            for (int unsigned i = 1; i < N_FEAT; i++) begin
              slot_d[i] = '0;
            end
          end
          for (int unsigned i = 0; i < N_FEAT; i++) begin
            if (idx_q == IDX_W'(i)) begin
              slot_d[i] = in_feat;
            end
          end
          idx_d = idx_q + IDX_W'(1);
          if (in_last != (idx_q == LAST_IDX)) begin
            err_d = 1'b1;
          end
          if (in_last || (idx_q == LAST_IDX)) begin
            state_d = S_SETTLE;
            cnt_d   = SETTLE_LD;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          out_class_d = cgp_out;
          out_err_d   = err_q;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (deliver_c) begin
          out_valid_d = 1'b0;
          out_seq_d   = out_seq_q + SEQ_W'(1);
          idx_d       = '0;
          err_d       = 1'b0;
          state_d     = S_FILL;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase

    in_ready_d = ready_en_q && (state_d == S_FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      ready_en_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      for (int unsigned i = 0; i < N_FEAT; i++) begin
        slot_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_class_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_seq_q   <= '0;
    end else begin
      state_q     <= state_d;
      ready_en_q  <= 1'b1;
      in_ready_q  <= in_ready_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_err_q   <= out_err_d;
      out_seq_q   <= out_seq_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign input_a   = slot_q[0];
  assign input_b   = slot_q[1];
  assign input_c   = slot_q[2];
  assign input_d   = slot_q[3];
  assign input_e   = slot_q[4];
  assign input_f   = slot_q[5];
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_err   = out_err_q;
  assign out_seq   = out_seq_q;

endmodule

// File: tb/tb_tnn_neuron_frame.sv
// Directed + randomized bench for tnn_neuron_frame; two instances (settle 1 and 4)
// share the stimulus bus, one selected at a time.
module tb_tnn_neuron_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_last, out_ready;
  logic [2:0]  in_feat;
  logic        sel;

  logic [1:0]  vld_i, rdy_o, ov_o, oc_o, oe_o, cgp;
  logic [7:0]  seq_o   [2];
  logic [17:0] slots_o [2];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_seq [2];
  logic [2:0] fr_feat [6];

  // Stand-in neuron: fires when the feature sum reaches 11.
  function automatic logic neuron(input logic [17:0] v);
    int s;
    s = 0;
    for (int i = 0; i < 6; i++) s += int'(v[3*i +: 3]);
    return (s >= 11);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [2:0] a, b, c, d, e, f;
    assign vld_i[g] = in_valid && (sel == 1'(g));
    tnn_neuron_frame #(.SETTLE(g == 0 ? 1 : 4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(vld_i[g]), .in_ready(rdy_o[g]),
      .in_feat(in_feat), .in_last(in_last),
      .input_a(a), .input_b(b), .input_c(c),
      .input_d(d), .input_e(e), .input_f(f),
      .cgp_out(cgp[g]),
      .out_valid(ov_o[g]), .out_ready(out_ready),
      .out_class(oc_o[g]), .out_err(oe_o[g]), .out_seq(seq_o[g])
    );
    assign slots_o[g] = {f, e, d, c, b, a};
    assign cgp[g]     = neuron(slots_o[g]);
  end

  logic rdy, ov, oc, oe;
  logic [7:0]  oseq;
  logic [17:0] oslots;
  always_comb begin
    rdy    = rdy_o[sel];
    ov     = ov_o[sel];
    oc     = oc_o[sel];
    oe     = oe_o[sel];
    oseq   = seq_o[sel];
    oslots = slots_o[sel];
  end

  function automatic int settle_of(input logic s);
    return s ? 4 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [2:0] f, input logic l);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_feat  = f;
    in_last  = l;
    while (!rdy && w < 40) begin
      step();
      w++;
    end
    chk("beat_ready", 32'(rdy), 32'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Frame of n beats; in_last on the final beat only if last_flag.
  task automatic run_frame(input int n, input logic last_flag, input int hold, input logic rnd);
    logic [17:0] exp_vec;
    logic        exp_err, exp_cls;
    int          lat;
    if (rnd) for (int i = 0; i < 6; i++) fr_feat[i] = 3'($urandom_range(0, 7));
    exp_vec = '0;
    for (int i = 0; i < n; i++) exp_vec[3*i +: 3] = fr_feat[i];
    exp_err = !(n == 6 && last_flag);
    exp_cls = neuron(exp_vec);

    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      send_beat(fr_feat[i], (i == n - 1) ? last_flag : 1'b0);
    end
    chk("slots_after_last", 32'(oslots), 32'(exp_vec));
    chk("valid_at_e0", 32'(ov), 32'd0);

    out_ready = (hold == 0);
    lat = 0;
    while (!ov && lat < 40) begin
      in_valid = 1'b1;
      in_feat  = 3'($urandom_range(0, 7));
      step();
      lat++;
      chk("ready_low_settle", 32'(rdy), 32'd0);
    end
    chk("latency", 32'(lat), 32'(settle_of(sel)));
    chk("class", 32'(oc), 32'(exp_cls));
    chk("err", 32'(oe), 32'(exp_err));
    chk("seq", 32'(oseq), 32'(exp_seq[sel]));

    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", 32'(ov), 32'd1);
      chk("hold_class", 32'(oc), 32'(exp_cls));
      chk("hold_ready", 32'(rdy), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("valid_after_deliver", 32'(ov), 32'd0);
    chk("ready_after_deliver", 32'(rdy), 32'd1);
    chk("slots_kept", 32'(oslots), 32'(exp_vec));
    exp_seq[sel] = exp_seq[sel] + 8'd1;
  endtask

  task automatic chk_reset_outs(input string tag);
    for (int s = 0; s < 2; s++) begin
      chk({tag, "_ready"}, 32'(rdy_o[s]), 32'd0);
      chk({tag, "_valid"}, 32'(ov_o[s]), 32'd0);
      chk({tag, "_class"}, 32'(oc_o[s]), 32'd0);
      chk({tag, "_err"}, 32'(oe_o[s]), 32'd0);
      chk({tag, "_seq"}, 32'(seq_o[s]), 32'd0);
      chk({tag, "_slots"}, 32'(slots_o[s]), 32'd0);
    end
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    step();
    chk("ready_first_edge", 32'(rdy_o), 32'd0);
    step();
    chk("ready_second_edge", 32'(rdy_o), 32'd3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_feat   = '0;
    out_ready = 1'b0;
    sel       = 1'b0;
    exp_seq[0] = '0;
    exp_seq[1] = '0;
    repeat (2) step();
    chk_reset_outs("reset");
    release_reset();

    // Full frame 1..6, out_ready held high across the frame.
    for (int i = 0; i < 6; i++) fr_feat[i] = 3'(i + 1);
    out_ready = 1'b1;
    run_frame(6, 1'b1, 0, 1'b0);

    // Truncated frame then a clean one.
    for (int i = 0; i < 6; i++) fr_feat[i] = 3'd7;
    run_frame(3, 1'b1, 0, 1'b0);
    run_frame(6, 1'b1, 0, 1'b1);

    // Missing in_last closes at six beats; next frame is clean.
    run_frame(6, 1'b0, 0, 1'b1);
    run_frame(6, 1'b1, 0, 1'b1);

    // Backpressure on the settle-4 instance.
    sel = 1'b1;
    run_frame(6, 1'b1, 10, 1'b1);
    run_frame(2, 1'b1, 3, 1'b1);
    run_frame(6, 1'b0, 0, 1'b1);

    // Sequence wrap with random frame shapes.
    sel = 1'b0;
    for (int k = 0; k < 257; k++) begin
      int n;
      n = $urandom_range(1, 6);
      run_frame(n, (n < 6) ? 1'b1 : 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b1);
    end

    // Reset mid-frame after three beats.
    for (int i = 0; i < 3; i++) send_beat(3'($urandom_range(1, 7)), 1'b0);
    rst_n = 1'b0;
    #2;
    chk_reset_outs("midframe_reset");
    step();
    exp_seq[0] = '0;
    exp_seq[1] = '0;
    release_reset();
    run_frame(6, 1'b1, 0, 1'b1);
    sel = 1'b1;
    run_frame(4, 1'b1, 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tnn_neuron_frame.md
# tnn_neuron_frame

Sequential front/back end for one combinational 3-bit ternary-NN neuron (six 3-bit operands `input_a`..`input_f`, one-bit `cgp_out`). It accepts a serial stream of 3-bit features over a valid/ready handshake and assembles them into a six-slot vector. It holds that vector stable on the neuron inputs for a programmable settle time, samples the neuron decision, and returns it downstream with a frame sequence number and a framing-error flag.

## Interface
- `N_FEAT`, 6: features per frame; fixed at 6.
- `FEAT_W`, 3: feature width in bits.
- `SETTLE`, 1: cycles between the last feature register update and the `cgp_out` sample; legal range 1..15.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `in_valid`  in  1  feature beat valid.
- `in_ready`  out  1  block accepts a beat.
- `in_feat`  in  3  feature value, unsigned.
- `in_last`  in  1  marks the final beat of a frame.
- `input_a`..`input_f`  out  3 each  registered neuron operands, slots 0..5.
- `cgp_out`  in  1  neuron decision, combinational from the slot outputs.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_class`  out  1  sampled `cgp_out`.
- `out_err`  out  1  framing error in this frame.
- `out_seq`  out  8  frame number of this result.

## Operation
- A beat is accepted when `in_valid & in_ready`. A result is delivered when `out_valid & out_ready`.
- The FSM has three states: FILL, SETTLE, HOLD. The reset state is FILL.
- **FILL**
  - `in_ready = 1`, except on the first cycle after reset release, which is held at 0 by a `ready_en` flop.
  - 3-bit index `idx` selects the slot; accepted beat k writes slot k (slot 0 = `input_a`, slot 5 = `input_f`).
  - The beat at `idx = 0` clears slots 1..5 in the same edge.
- **Frame end:** the frame ends on the beat with `in_last = 1` or the beat at `idx = 5`, whichever comes first.
  - FSM moves to SETTLE.
  - Settle counter loads `SETTLE - 1`.
  - Unwritten slots remain 0.
- **Framing error:** `err` is sticky per frame. It is set on any accepted beat where `in_last != (idx == 5)`. Two cases:
  - Early `in_last`: frame truncated and zero-padded.
  - Missing `in_last` at idx 5: frame closes anyway; the next beat starts a new frame.
- **SETTLE**
  - `in_ready = 0`.
  - Counter decrements each cycle.
  - At count 0: `out_class <= cgp_out`, `out_err <= err`, `out_valid <= 1`, FSM moves to HOLD.
- **HOLD**
  - Outputs are stable until delivery.
  - On delivery: `out_valid <= 0`, `out_seq <= out_seq + 1` (8-bit, 255 wraps to 0), `idx <= 0`, `err <= 0`, FSM moves to FILL.
  - Slots keep their values until the next frame's first beat.
- `out_seq` holds the number of frames delivered before the current one, so the first result has `out_seq = 0`.
- No overlap: a new frame is never accepted while a result is pending.

## Timing
- **Reset (async, `rst_n` low):**
  - `in_ready = 0`, `out_valid = 0`, `out_class = 0`, `out_err = 0`, `out_seq = 0`, slots = 0, `idx = 0`, FSM in FILL.
  - Effect is immediate and applies mid-frame or mid-HOLD; any partial frame or pending result is discarded.
- `in_ready` rises on the second rising edge after `rst_n` deasserts.
- **Latency:** if the frame-ending beat is accepted at edge E0, `out_valid` is high after edge E(SETTLE). With `SETTLE = 1`, that is the next edge. Slot outputs are valid after E0.
- **Back-to-back:** delivery at edge Ed gives `in_ready = 1` in the cycle after Ed. Minimum frame period is 6 + SETTLE + 1 cycles when `out_ready` is held high.
- `in_valid` is ignored while `in_ready = 0`. `out_ready` is ignored while `out_valid = 0`.
- `in_feat` is taken as-is (0..7). No arithmetic is performed on feature values.

## Test plan
- **Full frame, SETTLE = 1:**
  - Stimulus: features 1,2,3,4,5,6 with `in_last` on beat 6; neuron model returns 1; `out_ready` high.
  - Response: `input_a..f` = 1..6; `out_valid` one cycle after the 6th accept; `out_class = 1`, `out_err = 0`, `out_seq = 0`.
- **Truncated frame:**
  - Stimulus: 3 beats (7,7,7), `in_last` on beat 3.
  - Response: slots = 7,7,7,0,0,0; `out_err = 1`; next frame has `out_err = 0`.
- **Missing `in_last`:**
  - Stimulus: 6 beats, `in_last = 0`, then 6 more beats with `in_last` on beat 12.
  - Response: two results; first `out_err = 1`, second `out_err = 0`; `out_seq` 0 then 1.
- **Backpressure with SETTLE = 4:**
  - Stimulus: `out_ready` low for 10 cycles after `out_valid`.
  - Response: `out_valid` rises 4 edges after the last accept; `out_class` is stable; `in_ready = 0` throughout; one delivery.
- **Wrap and reset:**
  - Stimulus: deliver 257 frames, then assert `rst_n` low mid-frame (after beat 3).
  - Response: `out_seq` goes 255 then 0; after reset all outputs are 0 and the next result has `out_seq = 0` with beats 1..3 of the interrupted frame absent.
